// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the RV32I ALU issue/writeback sequencer:
//   - ALU opcode encoding (ALU_*)
//   - RV32I major opcodes handled by the sequencer (OPC_*)
//   - funct7 values that select the base/alternate operation (F7_*)
//   - FSM state encoding and the decoder result bundle
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam int XLEN    = 32;
  localparam int ALU_OPW = 4;

  localparam logic [ALU_OPW-1:0] ALU_ADD  = 4'd0;
  localparam logic [ALU_OPW-1:0] ALU_SUB  = 4'd1;
  localparam logic [ALU_OPW-1:0] ALU_AND  = 4'd2;
  localparam logic [ALU_OPW-1:0] ALU_OR   = 4'd3;
  localparam logic [ALU_OPW-1:0] ALU_XOR  = 4'd4;
  localparam logic [ALU_OPW-1:0] ALU_SLL  = 4'd5;
  localparam logic [ALU_OPW-1:0] ALU_SRL  = 4'd6;
  localparam logic [ALU_OPW-1:0] ALU_SRA  = 4'd7;
  localparam logic [ALU_OPW-1:0] ALU_SLT  = 4'd8;
  localparam logic [ALU_OPW-1:0] ALU_SLTU = 4'd9;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    WB     = 2'd3
  } state_e;

  // Everything the decoder hands back to the sequencer for one instruction.
  typedef struct packed {
    logic [ALU_OPW-1:0] op;
    logic [XLEN-1:0]    a;
    logic [XLEN-1:0]    b;
    logic [4:0]         rd;
    logic               illegal;
  } dec_t;

  // Base (funct7 = F7_BASE) operation selected by funct3, shared by OP and
  // OP-IMM; the alternate forms (SUB, SRA) are overridden by the decoder.
  function automatic logic [ALU_OPW-1:0] f3_op(input logic [2:0] funct3);
    case (funct3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// alu_seq_ctrl_if
// Bundles the three buses of the sequencer:
//   instruction handshake : instr_valid/instr_ready, instr, pc, rs1_data, rs2_data
//   ALU drive             : alu_op, alu_a, alu_b out; alu_y back (combinational)
//   writeback/completion  : rd_we, rd_addr, rd_wdata, done, illegal
// slave  : the sequencer itself
// master : the surrounding pipeline (instruction source, ALU, register file)
// -----------------------------------------------------------------------------
interface alu_seq_ctrl_if;
  import alu_pkg::*;

  logic               instr_valid;
  logic               instr_ready;
  logic [31:0]        instr;
  logic [XLEN-1:0]    pc;
  logic [XLEN-1:0]    rs1_data;
  logic [XLEN-1:0]    rs2_data;

  logic [ALU_OPW-1:0] alu_op;
  logic [XLEN-1:0]    alu_a;
  logic [XLEN-1:0]    alu_b;
  logic [XLEN-1:0]    alu_y;

  logic               rd_we;
  logic [4:0]         rd_addr;
  logic [XLEN-1:0]    rd_wdata;
  logic               done;
  logic               illegal;

  modport slave (
    input  instr_valid, instr, pc, rs1_data, rs2_data, alu_y,
    output instr_ready, alu_op, alu_a, alu_b,
    output rd_we, rd_addr, rd_wdata, done, illegal
  );

  modport master (
    output instr_valid, instr, pc, rs1_data, rs2_data, alu_y,
    input  instr_ready, alu_op, alu_a, alu_b,
    input  rd_we, rd_addr, rd_wdata, done, illegal
  );

endinterface

// File: rtl/rv32_alu_decode.sv
// -----------------------------------------------------------------------------
// rv32_alu_decode
// Purely combinational RV32I decoder for OP, OP-IMM, LUI and AUIPC.
//   instr : instruction word          pc  : its PC
//   rs1   : value of instr[19:15]     rs2 : value of instr[24:20]
//   dec   : {alu op, operand a, operand b, rd, illegal}
// Illegal encodings return op/a/b all zero so the ALU sees a quiet ADD 0+0.
// -----------------------------------------------------------------------------
module rv32_alu_decode
  import alu_pkg::*;
(
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output dec_t            dec
);

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;
  logic       shift_f7_ok;

  assign opcode      = instr[6:0];
  assign funct3      = instr[14:12];
  assign funct7      = instr[31:25];
  assign shift_f7_ok = (funct7 == F7_BASE) || (funct7 == F7_ALT);

  always_comb begin
    // NOTE: every field gets a default first so no path through the case
    // statement leaves a value unassigned and infers a latch.
    dec         = '0;
    dec.rd      = instr[11:7];
    dec.illegal = 1'b1;

    case (opcode)
      OPC_OP: begin
        dec.a       = rs1;
        dec.b       = rs2;
        dec.op      = f3_op(funct3);
        // F7_ALT only exists for SUB and SRA.
        dec.illegal = !((funct7 == F7_BASE) ||
                        (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)));
        if (funct7 == F7_ALT) dec.op = (funct3 == 3'b000) ? ALU_SUB : ALU_SRA;
      end

      OPC_OPIMM: begin
        dec.a       = rs1;
        dec.b       = {{20{instr[31]}}, instr[31:20]};
        dec.op      = f3_op(funct3);
        dec.illegal = 1'b0;
        // Shifts reuse the upper immediate bits as funct7 and take shamt only.
        if (funct3 == 3'b001) begin
          dec.b       = {27'b0, instr[24:20]};
          dec.illegal = (funct7 != F7_BASE);
        end else if (funct3 == 3'b101) begin
          dec.b       = {27'b0, instr[24:20]};
          dec.illegal = !shift_f7_ok;
          if (funct7 == F7_ALT) dec.op = ALU_SRA;
        end
      end

      OPC_LUI: begin
        dec.b       = {instr[31:12], 12'b0};
        dec.illegal = 1'b0;
      end

      OPC_AUIPC: begin
        dec.a       = pc;
        dec.b       = {instr[31:12], 12'b0};
        dec.illegal = 1'b0;
      end

      default: ;
    endcase

    if (dec.illegal) begin
      dec.op = ALU_ADD;
      dec.a  = '0;
      dec.b  = '0;
    end
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// -----------------------------------------------------------------------------
// alu_seq_ctrl
// Multi-cycle issue/writeback sequencer in front of an RV32I ALU.
//   clk   : rising-edge system clock
//   rst_n : asynchronous active-low reset
//   bus   : alu_seq_ctrl_if.slave (instruction handshake, ALU drive, writeback)
// Flow: IDLE (accept) -> DECODE (register ALU inputs) -> EXEC (capture alu_y)
//       -> WB (one-cycle done/rd_we) -> IDLE. One instruction per 4 cycles.
// -----------------------------------------------------------------------------
module alu_seq_ctrl
  import alu_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  alu_seq_ctrl_if.slave  bus
);

  state_e          state;
  state_e          state_next;
  logic [31:0]     instr_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] rs1_q;
  logic [XLEN-1:0] rs2_q;
  logic            illegal_q;
  logic            accept;
  dec_t            dec;

  assign accept = (state == IDLE) && bus.instr_valid;

  rv32_alu_decode u_decode (
    .instr (instr_q),
    .pc    (pc_q),
    .rs1   (rs1_q),
    .rs2   (rs2_q),
    .dec   (dec)
  );

  // State register.
  // NOTE: sequential logic uses non-blocking assignments so every flop
  // samples values from before the clock edge, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.instr_valid) state_next = DECODE;
      DECODE:  state_next = EXEC;
      EXEC:    state_next = WB;
      WB:      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic: strobes are pure functions of the state, so an async reset
  // drops them in the same instant it aborts the instruction.
  always_comb begin
    bus.instr_ready = (state == IDLE);
    bus.done        = (state == WB);
    bus.illegal     = (state == WB) && illegal_q;
    bus.rd_we       = (state == WB) && !illegal_q && (bus.rd_addr != 5'd0);
  end

  // Capture, ALU drive and writeback data registers. The ALU inputs hold
  // between DECODEs to keep the ALU datapath from toggling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q      <= '0;
      pc_q         <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      illegal_q    <= 1'b0;
      bus.alu_op   <= ALU_ADD;
      bus.alu_a    <= '0;
      bus.alu_b    <= '0;
      bus.rd_addr  <= '0;
      bus.rd_wdata <= '0;
    end else begin
      if (accept) begin
        instr_q <= bus.instr;
        pc_q    <= bus.pc;
        rs1_q   <= bus.rs1_data;
        rs2_q   <= bus.rs2_data;
      end
      if (state == DECODE) begin
        bus.alu_op  <= dec.op;
        bus.alu_a   <= dec.a;
        bus.alu_b   <= dec.b;
        bus.rd_addr <= dec.rd;
        illegal_q   <= dec.illegal;
      end
      if (state == EXEC) begin
        bus.rd_wdata <= illegal_q ? '0 : bus.alu_y;
      end
    end
  end

endmodule
